serial_addsub_resp: RTL and testbench
=====================================

Name: serial_addsub_resp

Overview:
- Bit-serial WIDTH-bit adder/subtractor with valid/ready handshakes on both sides.
- Acts as the responder to a stimulus initiator: it accepts an operand pair and an opcode, computes LSB-first through a single full-adder and a carry flop, then presents a (WIDTH+1)-bit result held until consumed.
- Sits behind a test driver or a control FSM that issues arithmetic requests and collects results.

Parameters:
- WIDTH, 4, operand width in bits; must be >= 1.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request presents A, B, op
- in_ready  output  1  block can accept a request
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- op  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  SUM is valid
- out_ready  input  1  consumer takes SUM
- SUM  output  WIDTH+1  result; SUM[WIDTH] is carry-out (add) or no-borrow flag (sub)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE, in_ready=1, out_valid=0, SUM=0, busy=0, counter=0, carry=0. Reset takes priority over all other events, including mid-RUN and DONE; any in-flight request is discarded and no result is produced.
- States:
  - IDLE: in_ready=1. Accept on the edge where in_valid&&in_ready.
    - Latch A into shift register SA and B^{WIDTH{op}} into SB.
    - carry <= op (subtract is A + ~B + 1).
    - counter <= 0; go to RUN.
  - RUN: in_ready=0. Each edge:
    - s = SA[0]^SB[0]^carry; carry <= majority(SA[0], SB[0], carry).
    - Shift s into the result register from the MSB side; shift SA and SB right by one.
    - counter++.
    - On the edge where counter==WIDTH-1: go to DONE and load SUM = {carry_out, result bits}.
  - DONE: out_valid=1, SUM stable.
    - On the edge where out_valid&&out_ready: out_valid <= 0, go to IDLE.
    - No new request is accepted in the same edge; in_ready rises the cycle after the handoff.
- Latency: with the accept at edge E0, out_valid is high after edge E_WIDTH (4 edges for WIDTH=4). Throughput is one request per WIDTH+2 cycles when out_ready is held high.
- Inputs A, B, op are sampled only at the accept edge; later changes have no effect.
- in_valid while not in IDLE is ignored (not queued).
- out_ready while out_valid=0 is ignored.
- Arithmetic, width WIDTH+1, no overflow possible:
  - Add: SUM = A+B, range 0..2^(WIDTH+1)-2.
  - Sub: SUM[WIDTH-1:0] = (A-B) mod 2^WIDTH; SUM[WIDTH] = 1 iff A>=B.
- Backpressure: SUM and out_valid hold indefinitely while out_ready=0.
- SUM retains its last value in IDLE and RUN; it is not cleared except by rst.
- WIDTH=1: RUN lasts exactly one edge.

Test Plan:
- Reset, then add 0001+0010, out_ready=1: accept at E0, out_valid after E4, SUM=00011, one-cycle valid pulse, in_ready high one cycle later.
- Add 1111+0001 -> SUM=10000. Add 1010+0101 -> SUM=01111. Add 1010+0000 -> SUM=01010.
- Sub 0101-0011 -> SUM=1_0010. Sub 0011-0101 -> SUM=0_1110. Sub 0000-0000 -> SUM=1_0000.
- Backpressure on 0101+0011: out_ready=0 for 5 cycles -> out_valid stays 1 and SUM=01000 stable; in_ready=0; in_valid pulses with new operands are ignored; out_ready=1 -> handoff, next accept one cycle later.
- Operand churn: change A, B, op every cycle during RUN after accepting 0001+0010 -> SUM still 00011.
- Reset mid-operation: assert rst at RUN counter=2 -> next cycle IDLE, out_valid=0, SUM=0, in_ready=1; a following request for 1111+0001 yields 10000 with normal latency.

Source files
------------

// File: rtl/serial_addsub_resp.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_resp
// Purpose  : Bit-serial WIDTH-bit adder/subtractor with valid/ready handshakes.
//            Accepts {A, B, op} in IDLE. Computes LSB-first through a single
//            full adder and a carry flop over WIDTH cycles. Then holds the
//            (WIDTH+1)-bit result in DONE until the consumer takes it.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            in_valid/in_ready, A, B, op   - request side (op: 0 add, 1 sub)
//            out_valid/out_ready, SUM      - result side; SUM[WIDTH] is the
//                                            carry-out (add) or no-borrow (sub)
//            busy                          - high while in RUN or DONE
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_resp #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   SUM,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH:0]   r_sum;

    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    // Single full adder on the current LSBs.
    assign w_s    = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_cout = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
    assign w_last = (r_cnt == c_last_cnt);

    // The new sum bit enters from the MSB side, so after WIDTH shifts the
    // first (LSB) bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_nxt = w_s;
        end else begin : g_res_wn
            assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath. Subtraction is A + ~B + 1: B is inverted on load and the
    // carry is seeded with op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sa    <= A;
                        r_sb    <= B ^ {WIDTH{op}};
                        r_carry <= op;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_carry <= w_cout;
                    r_res   <= w_res_nxt;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum <= {w_cout, w_res_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign SUM       = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub_resp
// Purpose  : Self-checking bench for serial_addsub_resp (WIDTH=4). A vector
//            table is applied in a loop. Hand-written sequences cover
//            backpressure, operand churn and reset during RUN. Expected sums
//            are queued at accept and compared at the handoff.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_resp;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   SUM;
    logic             busy;

    serial_addsub_resp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             o;
        logic [WIDTH:0]   exp;
    } vec_t;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [WIDTH:0] sb_q[$];
    vec_t           tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for one edge (the accept edge E0) and queue its result.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic o, input logic [WIDTH:0] exp);
        check("in_ready_idle", in_ready, 1);
        A        = a;
        B        = b;
        op       = o;
        in_valid = 1'b1;
        sb_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        check("in_ready_run", in_ready, 0);
        check("busy_run", busy, 1);
    endtask

    // Count edges after E0 until out_valid; optionally scramble inputs.
    task automatic wait_valid(input bit churn);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (churn) begin
                A  = WIDTH'($urandom);
                B  = WIDTH'($urandom);
                op = 1'($urandom);
            end
            tick();
            lat++;
        end
        check("latency", lat, WIDTH);
    endtask

    // Handoff with out_ready=1; result compared against the scoreboard.
    task automatic collect();
        logic [WIDTH:0] exp;
        out_ready = 1'b1;
        check("out_valid_done", out_valid, 1);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            exp = sb_q.pop_front();
            check("sum", SUM, exp);
        end
        tick();
        check("out_valid_after_handoff", out_valid, 0);
        check("in_ready_after_handoff", in_ready, 1);
        check("busy_after_handoff", busy, 0);
    endtask

    initial begin
        tbl[0] = '{4'b0001, 4'b0010, 1'b0, 5'b00011};
        tbl[1] = '{4'b1111, 4'b0001, 1'b0, 5'b10000};
        tbl[2] = '{4'b1010, 4'b0101, 1'b0, 5'b01111};
        tbl[3] = '{4'b1010, 4'b0000, 1'b0, 5'b01010};
        tbl[4] = '{4'b0101, 4'b0011, 1'b1, 5'b10010};
        tbl[5] = '{4'b0011, 4'b0101, 1'b1, 5'b01110};
        tbl[6] = '{4'b0000, 4'b0000, 1'b1, 5'b10000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        op        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", SUM, 0);
        check("rst_busy", busy, 0);

        // Vector table, out_ready held high.
        for (int i = 0; i < 7; i++) begin
            accept(tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].exp);
            wait_valid(1'b0);
            collect();
        end

        // Backpressure: result must hold and new requests must be ignored.
        out_ready = 1'b0;
        accept(4'b0101, 4'b0011, 1'b0, 5'b01000);
        wait_valid(1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_sum", SUM, 5'b01000);
            check("bp_in_ready", in_ready, 0);
            A        = 4'b1111;
            B        = 4'b1111;
            op       = 1'b1;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        collect();
        // Next accept one cycle after the handoff.
        accept(4'b0011, 4'b0101, 1'b1, 5'b01110);
        wait_valid(1'b0);
        collect();

        // Operand churn during RUN has no effect.
        accept(4'b0001, 4'b0010, 1'b0, 5'b00011);
        wait_valid(1'b1);
        collect();

        // Reset at RUN counter=2 discards the request.
        accept(4'b1111, 4'b1111, 1'b0, 5'b11110);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb_q.pop_back());
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", SUM, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_result", out_valid, 0);
        end
        accept(4'b1111, 4'b0001, 1'b0, 5'b10000);
        wait_valid(1'b0);
        collect();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
